contador_ctrl: RTL

CONTADOR_CTRL -- requirements
Module: contador_ctrl

---
 rtl/contador_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/contador_ctrl.sv
`default_nettype none
// ============================================================================
// contador_ctrl : up/down button controller for an 8-bit saturating counter,
//                 with press-and-hold auto-repeat, lockout and clear.
// Revision      : 1.0
// ============================================================================
module contador_ctrl #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int MAX_COUNT    = 255
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       boton_up_i,
  input  logic       boton_down_i,
  input  logic       clear_i,
  input  logic [7:0] conta_i,
  output logic       inc_o,
  output logic       dec_o,
  output logic       clr_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    REPEAT = 3'd2,
    LOCK   = 3'd3
  } state_t;

  localparam logic [15:0] c_HOLD_LAST = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] c_REP_LAST  = 16'(REPEAT_TICKS - 1);
  localparam logic [7:0]  c_MAX       = 8'(MAX_COUNT);

  state_t      r_state, w_state_nxt;
  logic        r_dir, w_dir_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic        r_up_prev, r_dn_prev, r_clr_prev;
  logic        r_inc, r_dec, r_clr;
  logic        w_inc_nxt, w_dec_nxt, w_clr_nxt, w_fire;
  logic        w_up_press, w_dn_press, w_active, w_opposite;

  assign w_up_press = boton_up_i & ~r_up_prev;
  assign w_dn_press = boton_down_i & ~r_dn_prev;
  assign w_active   = r_dir ? boton_up_i : boton_down_i;
  assign w_opposite = r_dir ? boton_down_i : boton_up_i;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_fire      = 1'b0;
    w_clr_nxt   = 1'b0;
    // A held clear freezes everything after its first edge.
    if (clear_i) begin
      if (!r_clr_prev) begin
        w_clr_nxt   = 1'b1;
        w_timer_nxt = 16'd0;
        w_state_nxt = (boton_up_i | boton_down_i) ? LOCK : IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_up_press && w_dn_press) begin
            w_state_nxt = LOCK;
          end else if (w_up_press || w_dn_press) begin
            w_fire      = 1'b1;
            w_dir_nxt   = w_up_press;
            w_timer_nxt = 16'd0;
            w_state_nxt = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!w_active) begin
            w_state_nxt = IDLE;
            w_timer_nxt = 16'd0;
          end else if (w_opposite) begin
            w_state_nxt = LOCK;
            w_timer_nxt = 16'd0;
          end else if (tick_i) begin
            if (r_timer == ((r_state == HOLD) ? c_HOLD_LAST : c_REP_LAST)) begin
              w_fire      = 1'b1;
              w_timer_nxt = 16'd0;
              w_state_nxt = REPEAT;
            end else begin
              w_timer_nxt = r_timer + 16'd1;
            end
          end
        end
        LOCK: begin
          if (!boton_up_i && !boton_down_i) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Commands at the counter bounds are dropped; the FSM still moves on.
  assign w_inc_nxt = w_fire & w_dir_nxt & (conta_i != c_MAX);
  assign w_dec_nxt = w_fire & ~w_dir_nxt & (conta_i != 8'd0);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_dir      <= 1'b1;
      r_timer    <= 16'd0;
      r_up_prev  <= 1'b0;
      r_dn_prev  <= 1'b0;
      r_clr_prev <= 1'b0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_clr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_timer    <= w_timer_nxt;
      r_up_prev  <= boton_up_i;
      r_dn_prev  <= boton_down_i;
      r_clr_prev <= clear_i;
      r_inc      <= w_inc_nxt;
      r_dec      <= w_dec_nxt;
      r_clr      <= w_clr_nxt;
    end
  end

  assign inc_o   = r_inc;
  assign dec_o   = r_dec;
  assign clr_o   = r_clr;
  assign state_o = r_state;

endmodule
`default_nettype wire
